// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing and shared types for the multi-port GPR file.
// Default widths used by decode and by the write-request bundle.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int NUM_RD   = 3;
    localparam int NUM_WR   = 2;
    localparam int AW       = $clog2(NUM_REGS);

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_if.sv
// regfile_if: read, write, alloc and scoreboard signals of regfile_mp.
// master drives requests (decode/writeback), slave is the register file.
interface regfile_if #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int NUM_RD   = regfile_pkg::NUM_RD,
    parameter int NUM_WR   = regfile_pkg::NUM_WR
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0]             rd_en;
    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][AW-1:0]     wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]             wr_ack;
    logic [NUM_WR-1:0]             wr_conflict;
    logic                          alloc_en;
    logic [AW-1:0]                 alloc_addr;
    logic [NUM_REGS-1:0]           busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output alloc_en, alloc_addr,
        input  rd_data, rd_busy, wr_ack, wr_conflict, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  alloc_en, alloc_addr,
        output rd_data, rd_busy, wr_ack, wr_conflict, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for pending writebacks.
// Alloc beats a same-cycle committed write; busy_nxt feeds read bypass.
module rf_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ZERO_REG = 0,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [NUM_REGS-1:0] clr,
    output logic [NUM_REGS-1:0] busy,
    output logic [NUM_REGS-1:0] busy_nxt
);

    logic [NUM_REGS-1:0] set;

    always_comb begin
        set = '0;
        if (alloc_en) set[alloc_addr] = 1'b1;
        busy_nxt = (busy & ~clr) | set;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with write bypass and busy scoreboard.
// Highest-index writer wins on an address clash; reads see post-write state.
module regfile_mp #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int NUM_RD   = regfile_pkg::NUM_RD,
    parameter int NUM_WR   = regfile_pkg::NUM_WR,
    parameter int ZERO_REG = 0
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);

    typedef struct packed {
        logic              en;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t [NUM_WR-1:0]               req;
    logic [NUM_WR-1:0]               shadowed;
    logic [NUM_WR-1:0]               zero_hit;
    logic [NUM_WR-1:0]               commit;
    logic [NUM_WR-1:0]               conflict;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_nxt;
    logic [NUM_REGS-1:0]             clr;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             busy_nxt;

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            req[j].en   = bus.wr_en[j];
            req[j].addr = bus.wr_addr[j];
            req[j].data = bus.wr_data[j];
        end
    end

    // A port is shadowed when any higher-index port writes the same address.
    always_comb begin
        shadowed = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (req[k].en && req[k].addr == req[j].addr)
                    shadowed[j] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            zero_hit[j] = (ZERO_REG != 0) && (req[j].addr == '0);
            commit[j]   = req[j].en && !zero_hit[j] && !shadowed[j];
            conflict[j] = req[j].en && !zero_hit[j] && shadowed[j];
        end
    end

    always_comb begin
        regs_nxt = regs;
        clr      = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (commit[j]) begin
                regs_nxt[req[j].addr] = req[j].data;
                clr[req[j].addr]      = 1'b1;
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .clr        (clr),
        .busy       (busy),
        .busy_nxt   (busy_nxt)
    );

    assign bus.busy_vec = busy;

    always_ff @(posedge clk) begin
        if (rst) regs <= '0;
        else     regs <= regs_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data     <= '0;
            bus.rd_busy     <= '0;
            bus.wr_ack      <= '0;
            bus.wr_conflict <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (bus.rd_en[i]) begin
                    bus.rd_data[i] <= regs_nxt[bus.rd_addr[i]];
                    bus.rd_busy[i] <= busy_nxt[bus.rd_addr[i]];
                end
            end
            bus.wr_ack      <= commit;
            bus.wr_conflict <= conflict;
        end
    end

endmodule
